// File: rtl/pdp8_io_intctl.sv
// PDP-8 IOT bus controller: merges peripheral IOT responses, decodes device-00
// processor IOTs, and sequences the ION delay into a registered interrupt request.
module pdp8_io_intctl #(
  parameter int NDEV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iot,
  input  logic [3:0]           state,
  input  logic [11:0]          mb,
  input  logic [5:0]           io_select,
  input  logic [11:0]          io_data_in,
  input  logic [NDEV-1:0]      dev_selected,
  input  logic [NDEV-1:0]      dev_skip,
  input  logic [12*NDEV-1:0]   dev_data,
  input  logic [NDEV-1:0]      dev_irq,
  input  logic                 int_ack,
  output logic                 io_selected,
  output logic [11:0]          io_data_out,
  output logic                 io_skip,
  output logic                 interrupt_req,
  output logic                 ion,
  output logic [3:0]           irq_vector,
  output logic                 bus_conflict
);

  localparam logic [3:0] F1 = 4'b0001;
  localparam logic [3:0] F3 = 4'b0011;

  typedef enum logic [1:0] {ION_OFF, ION_ARM, ION_WAIT, ION_ON} ion_t;

  ion_t            ion_st, ion_nxt;
  logic [NDEV-1:0] mask, mask_nxt, pend;
  logic [11:0]     mask_ext, slot_data;
  logic            slot_skip;
  logic            qual, dev00;
  logic [2:0]      fn;
  logic [NDEV:0]   claim;
  logic            multi_claim;
  logic            unused_mb;

  // Opcode and device-code bits of mb are already conveyed by iot and io_select.
  assign unused_mb = ^mb[11:3];

  assign qual  = (state == F1) && iot;
  assign dev00 = qual && (io_select == 6'd0);
  assign fn    = mb[2:0];
  assign pend  = dev_irq & mask;
  assign ion   = (ion_st == ION_ON);

  always_comb begin
    mask_ext = '0;
    mask_ext[NDEV-1:0] = mask;
  end

  // Walk from the top so the lowest-index claimant is the last writer.
  always_comb begin
    slot_data = '0;
    slot_skip = 1'b0;
    for (int i = NDEV-1; i >= 0; i--) begin
      if (dev_selected[i]) begin
        slot_data = dev_data[12*i +: 12];
        slot_skip = dev_skip[i];
      end
    end
  end

  always_comb begin
    irq_vector = 4'd0;
    for (int i = NDEV-1; i >= 0; i--)
      if (pend[i]) irq_vector = 4'(i);
  end

  always_comb begin
    io_data_out = io_data_in;
    io_skip     = 1'b0;
    io_selected = 1'b0;
    if (qual) begin
      io_selected = (|dev_selected) | dev00;
      if (dev00) begin
        case (fn)
          3'd0:    io_skip = ion;
          3'd3:    io_skip = |pend;
          3'd7:    io_data_out = mask_ext;
          default: ;
        endcase
      end else if (|dev_selected) begin
        io_data_out = slot_data;
        io_skip     = slot_skip;
      end
    end
  end

  always_comb begin
    ion_nxt = ion_st;
    case (ion_st)
      ION_OFF:  if (dev00 && fn == 3'd1) ion_nxt = ION_ARM;
      ION_ARM:  if (state == F3) ion_nxt = ION_WAIT;
      ION_WAIT: if (state == F3) ion_nxt = ION_ON;
      ION_ON:   if (int_ack) ion_nxt = ION_OFF;
      default:  ion_nxt = ION_OFF;
    endcase
    if (dev00 && (fn == 3'd0 || fn == 3'd2)) ion_nxt = ION_OFF;
  end

  always_comb begin
    mask_nxt = mask;
    if (dev00 && fn == 3'd6) mask_nxt = io_data_in[NDEV-1:0];
  end

  assign claim       = {dev_selected, dev00};
  assign multi_claim = |(claim & (claim - (NDEV+1)'(1)));

  // interrupt_req looks at the mask being written this edge, so LMSK takes effect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ion_st        <= ION_OFF;
      mask          <= '1;
      interrupt_req <= 1'b0;
      bus_conflict  <= 1'b0;
    end else begin
      ion_st        <= ion_nxt;
      mask          <= mask_nxt;
      interrupt_req <= (ion_nxt == ION_ON) && |(dev_irq & mask_nxt) && !int_ack;
      if (qual && multi_claim) bus_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pdp8_io_intctl.sv
// Directed vector bench for pdp8_io_intctl (NDEV=4): table of {inputs, expected}
// applied one clock each, plus a hand-written async-reset sequence.
module tb_pdp8_io_intctl;

  localparam int NDEV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              iot;
  logic [3:0]        state;
  logic [11:0]       mb;
  logic [5:0]        io_select;
  logic [11:0]       io_data_in;
  logic [NDEV-1:0]   dev_selected, dev_skip, dev_irq;
  logic [12*NDEV-1:0] dev_data;
  logic              int_ack;
  logic              io_selected, io_skip, interrupt_req, ion, bus_conflict;
  logic [11:0]       io_data_out;
  logic [3:0]        irq_vector;

  pdp8_io_intctl #(.NDEV(NDEV)) dut (
    .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
    .io_select(io_select), .io_data_in(io_data_in),
    .dev_selected(dev_selected), .dev_skip(dev_skip), .dev_data(dev_data),
    .dev_irq(dev_irq), .int_ack(int_ack),
    .io_selected(io_selected), .io_data_out(io_data_out), .io_skip(io_skip),
    .interrupt_req(interrupt_req), .ion(ion), .irq_vector(irq_vector),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  // Expected register outputs (ion, ireq, conf) are the values before this row's clock edge.
  typedef struct {
    logic [3:0]  st;
    logic        iot;
    logic [11:0] mb;
    logic [11:0] ac;
    logic [3:0]  sel;
    logic [3:0]  skp;
    logic [47:0] dat;
    logic [3:0]  irq;
    logic        ack;
    logic        e_sel;
    logic [11:0] e_dout;
    logic        e_skip;
    logic        e_ion;
    logic        e_ireq;
    logic [3:0]  e_vec;
    logic        e_conf;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  localparam logic [3:0] F0 = 4'd0, F1 = 4'd1, F2 = 4'd2, F3 = 4'd3;

  function automatic vec_t mk(logic [3:0] st, logic iot_i, logic [11:0] mb_i, logic [11:0] ac,
                              logic [3:0] sel, logic [3:0] skp, logic [47:0] dat,
                              logic [3:0] irq, logic ack,
                              logic e_sel, logic [11:0] e_dout, logic e_skip,
                              logic e_ion, logic e_ireq, logic [3:0] e_vec, logic e_conf);
    vec_t v;
    v.st = st; v.iot = iot_i; v.mb = mb_i; v.ac = ac; v.sel = sel; v.skp = skp;
    v.dat = dat; v.irq = irq; v.ack = ack;
    v.e_sel = e_sel; v.e_dout = e_dout; v.e_skip = e_skip; v.e_ion = e_ion;
    v.e_ireq = e_ireq; v.e_vec = e_vec; v.e_conf = e_conf;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [11:0] act, logic [11:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s step %0d: got %o want %o", nm, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    state = v.st; iot = v.iot; mb = v.mb; io_select = v.mb[8:3]; io_data_in = v.ac;
    dev_selected = v.sel; dev_skip = v.skp; dev_data = v.dat; dev_irq = v.irq;
    int_ack = v.ack;
  endtask

  task automatic check(vec_t v, int idx);
    nvec++;
    chk("io_selected", idx, {11'd0, io_selected}, {11'd0, v.e_sel});
    chk("io_data_out", idx, io_data_out, v.e_dout);
    chk("io_skip", idx, {11'd0, io_skip}, {11'd0, v.e_skip});
    chk("ion", idx, {11'd0, ion}, {11'd0, v.e_ion});
    chk("interrupt_req", idx, {11'd0, interrupt_req}, {11'd0, v.e_ireq});
    chk("irq_vector", idx, {8'd0, irq_vector}, {8'd0, v.e_vec});
    chk("bus_conflict", idx, {11'd0, bus_conflict}, {11'd0, v.e_conf});
  endtask

  // Drive at negedge, sample 2ns later (3ns before the rising edge), then clock.
  task automatic step(vec_t v, int idx);
    @(negedge clk);
    drive(v);
    #2;
    check(v, idx);
    @(posedge clk);
  endtask

  localparam logic [47:0] D0 = 48'd0;
  localparam logic [47:0] DCONF = {12'o0000, 12'o5670, 12'o1234, 12'o0000};
  localparam logic [47:0] DONE3 = {12'o0055, 12'o0000, 12'o0000, 12'o0000};
  localparam logic [47:0] DONE0 = {12'o0000, 12'o0000, 12'o0000, 12'o7777};

  initial begin
    //              st  iot mb       ac       sel      skp      dat    irq      ack  sel dout     skp ion irq vec conf
    // reset state, RMSK
    tbl.push_back(mk(F1, 1, 12'o6007, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0,  1, 12'o0017, 0, 0, 0, 0, 0));
    // ION, delay one instruction, interrupt, int_ack
    tbl.push_back(mk(F1, 1, 12'o6001, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0,  1, 12'o0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F3, 0, 12'o6001, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0,  0, 12'o0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0,  0, 12'o0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F1, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0,  0, 12'o0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F3, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0,  0, 12'o0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 1,  0, 12'o0000, 0, 1, 1, 0, 0));
    tbl.push_back(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0,  0, 12'o0000, 0, 0, 0, 0, 0));
    // ION then IOF: never interrupts; SRQ skips
    tbl.push_back(mk(F1, 1, 12'o6001, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0010, 0,  1, 12'o0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(F3, 0, 12'o6001, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0010, 0,  0, 12'o0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(F1, 1, 12'o6002, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0010, 0,  1, 12'o0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(F3, 0, 12'o6002, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0010, 0,  0, 12'o0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(F3, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0010, 0,  0, 12'o0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(F1, 1, 12'o6003, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0010, 0,  1, 12'o0000, 1, 0, 0, 1, 0));
    // LMSK 0004 with irq 0101 -> vector 2, then ION
    tbl.push_back(mk(F1, 1, 12'o6006, 12'o0004, 4'b0000, 4'b0000, D0, 4'b0101, 0,  1, 12'o0004, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F3, 0, 12'o6006, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  0, 12'o0000, 0, 0, 0, 2, 0));
    tbl.push_back(mk(F1, 1, 12'o6001, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  1, 12'o0000, 0, 0, 0, 2, 0));
    tbl.push_back(mk(F3, 0, 12'o6001, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  0, 12'o0000, 0, 0, 0, 2, 0));
    tbl.push_back(mk(F1, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  0, 12'o0000, 0, 0, 0, 2, 0));
    tbl.push_back(mk(F3, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  0, 12'o0000, 0, 0, 0, 2, 0));
    tbl.push_back(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  0, 12'o0000, 0, 1, 1, 2, 0));
    // LMSK 0000 drops the request; LMSK 0017 restores it; irq drop clears it next edge
    tbl.push_back(mk(F1, 1, 12'o6006, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  1, 12'o0000, 0, 1, 1, 2, 0));
    tbl.push_back(mk(F3, 0, 12'o6006, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0101, 0,  0, 12'o0000, 0, 1, 0, 0, 0));
    tbl.push_back(mk(F1, 1, 12'o6006, 12'o0017, 4'b0000, 4'b0000, D0, 4'b0101, 0,  1, 12'o0017, 0, 1, 0, 0, 0));
    tbl.push_back(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0,  0, 12'o0000, 0, 1, 1, 0, 0));
    tbl.push_back(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0,  0, 12'o0000, 0, 1, 0, 0, 0));
    // SKON with ion on: skips, then ion off
    tbl.push_back(mk(F1, 1, 12'o6000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0,  1, 12'o0000, 1, 1, 0, 0, 0));
    tbl.push_back(mk(F3, 0, 12'o6000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0,  0, 12'o0000, 0, 0, 0, 0, 0));
    // unclaimed device 35; unqualified (F2) claim is ignored
    tbl.push_back(mk(F1, 1, 12'o6351, 12'o4321, 4'b0000, 4'b0000, D0, 4'b0000, 0,  0, 12'o4321, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F2, 1, 12'o6351, 12'o1111, 4'b0001, 4'b0001, DONE0, 4'b0000, 0, 0, 12'o1111, 0, 0, 0, 0, 0));
    // two claimants: lowest slot wins, bus_conflict sticks
    tbl.push_back(mk(F1, 1, 12'o6401, 12'o0000, 4'b0110, 4'b0100, DCONF, 4'b0000, 0, 1, 12'o1234, 0, 0, 0, 0, 0));
    tbl.push_back(mk(F3, 0, 12'o6401, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0,  0, 12'o0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(F1, 1, 12'o6421, 12'o0000, 4'b1000, 4'b1000, DONE3, 4'b0000, 0, 1, 12'o0055, 1, 0, 0, 0, 1));
    tbl.push_back(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0,  0, 12'o0000, 0, 0, 0, 0, 1));

    reset = 1'b1;
    drive(mk(F0, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0000, 0, 0, 12'o0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Async reset in ION_WAIT with mask=0: immediate clear, mask back to all ones, no interrupt.
    step(mk(F1, 1, 12'o6006, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0, 1, 12'o0000, 0, 0, 0, 0, 1), 100);
    step(mk(F1, 1, 12'o6001, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0, 1, 12'o0000, 0, 0, 0, 0, 1), 101);
    step(mk(F3, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0, 0, 12'o0000, 0, 0, 0, 0, 1), 102);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    nvec++;
    chk("async_reset_conflict", 103, {11'd0, bus_conflict}, 12'd0);
    chk("async_reset_vector", 103, {8'd0, irq_vector}, 12'd0 + 12'(dev_irq[0] ? 0 : 0));
    #1 reset = 1'b0;
    step(mk(F3, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0, 0, 12'o0000, 0, 0, 0, 0, 0), 104);
    step(mk(F3, 0, 12'o7000, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0, 0, 12'o0000, 0, 0, 0, 0, 0), 105);
    step(mk(F1, 1, 12'o6007, 12'o0000, 4'b0000, 4'b0000, D0, 4'b0001, 0, 1, 12'o0017, 0, 0, 0, 0, 0), 106);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pdp8_io_intctl.md
# pdp8_io_intctl

Central IOT bus controller and interrupt sequencer for the PDP-8 core. It merges the IOT responses of up to NDEV peripheral devices (console TTY, disk, clock, …) into a single response to the CPU. It decodes the device-00 processor IOTs (ION/IOF/SKON/SRQ plus mask load/read) and runs the ION-delay state machine. It raises the interrupt request that the CPU samples at the end of each instruction.

## Interface
Parameters:
- NDEV, 4: number of peripheral device slots, 1..12; slot 0 has the highest priority.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iot  in  1  current instruction is an IOT
- state  in  4  CPU major state; F0=0000, F1=0001, F2=0010, F3=0011
- mb  in  12  memory buffer (IOT instruction word)
- io_select  in  6  device code, mb[8:3]
- io_data_in  in  12  AC value presented to devices
- dev_selected  in  NDEV  per-slot "device claimed this IOT"
- dev_skip  in  NDEV  per-slot skip response
- dev_data  in  12*NDEV  per-slot data; slot i occupies [12i+11:12i]
- dev_irq  in  NDEV  per-slot level interrupt request
- int_ack  in  1  one-cycle pulse when the CPU enters its interrupt cycle
- io_selected  out  1  some device (or device 00) claimed the IOT
- io_data_out  out  12  merged data to AC
- io_skip  out  1  merged skip
- interrupt_req  out  1  registered; take an interrupt at the end of this instruction
- ion  out  1  interrupt system enabled (ION_ON state)
- irq_vector  out  4  index of the highest-priority pending masked request
- bus_conflict  out  1  sticky flag: more than one claimant on one IOT

## Operation
- Response merge is combinational and is qualified by state==F1 && iot. When it is not qualified, all outputs take their defaults: io_data_out=io_data_in, io_skip=0, io_selected=0.
- Slot selection: the lowest-index slot with dev_selected=1 drives io_data_out and io_skip. io_selected = OR of all dev_selected and the device-00 decode.
- Device 00 (io_select==0) is handled internally. mb[2:0] selects the function:
  - 0 SKON: skip if ion, then go to ION_OFF.
  - 1 ION: go to ION_ARM.
  - 2 IOF: go to ION_OFF.
  - 3 SRQ: skip if any masked request is pending.
  - 6 LMSK: mask <= io_data_in[NDEV-1:0].
  - 7 RMSK: io_data_out = zero-extended mask.
  - 4 and 5: selected, no operation, data passes through.
- Pending request: pend = dev_irq & mask. irq_vector = lowest set index of pend, or 0 when pend is empty.
- ION state machine; all register updates happen on the rising edge of clk:
  - ION_OFF: on ION at F1, go to ION_ARM.
  - ION_ARM: at F3 (end of the ION instruction), go to ION_WAIT.
  - ION_WAIT: at the next F3 (end of the following instruction), go to ION_ON.
  - ION_ON: int_ack goes to ION_OFF.
  - From any state, IOF or SKON at F1 goes to ION_OFF.
  - ION decoded while already in ION_ON keeps ION_ON.
- interrupt_req is registered: next value = (next ion state == ION_ON) && |pend. It is cleared in the same edge that takes int_ack.
- bus_conflict is set when, in state F1 with iot=1, the count of claimants (including device 00) is 2 or more. It is cleared only by reset.
- mask resets to all ones.

## Timing
- Reset values: ion state ION_OFF, ion=0, interrupt_req=0, bus_conflict=0, mask=all ones. Combinational outputs follow their defaults.
- Merge path has zero latency. It must settle within the F1 cycle, because the CPU samples skip and data at the end of F1.
- Device-00 register effects (mask, ion state) become visible one clk after the F1 edge.
- ION effect: at least one full instruction after the ION instruction executes before interrupt_req can rise. The earliest rise is the edge that ends F3 of the instruction following ION.
- int_ack and an ION decode never coincide, because int_ack is not issued in F1. If int_ack arrives while in ION_ARM or ION_WAIT, the state is unchanged.
- dev_irq drop while interrupt_req=1: interrupt_req falls on the next edge.
- Reset mid-sequence (ARM or WAIT) returns immediately and asynchronously to ION_OFF.

## Test plan
- Reset, then RMSK (IOT 6007) at F1 with NDEV=4 -> io_data_out=0017, io_selected=1, ion=0, interrupt_req=0.
- ION (6001), next instruction, dev_irq=0001 held -> interrupt_req=0 through the F3 of ION, rises after the F3 of the next instruction; int_ack -> ion=0 and interrupt_req=0 the next cycle.
- ION then IOF (6002) as the next instruction with dev_irq=0010 -> interrupt_req never rises; SRQ (6003) -> io_skip=1.
- LMSK with AC=0004 and dev_irq=0101 -> irq_vector=2; with ion on -> interrupt_req=1; LMSK AC=0000 -> interrupt_req=0 next cycle.
- F1 IOT with dev_selected=0110, dev_data slot1=1234, slot2=5670, dev_skip=0100 -> io_data_out=1234, io_skip=0, bus_conflict=1 and it stays set afterwards.
- No device claims io_select=35 with AC=4321 -> io_selected=0, io_data_out=4321, io_skip=0; SKON with ion=1 -> io_skip=1 and ion=0 next cycle.
